pipe_addsub: RTL and testbench
==============================

// Module: pipe_addsub
// PURPOSE
//  Parametrised, pipelined N-bit adder/subtractor with valid/ready handshake and status flags.
//  Splits the carry chain into STAGES ripple chunks, one chunk per clock stage.
//  Successor to the combinational ripple adder. Sits in the datapath ahead of the ALU result mux.
// PARAMETERS
//  N       8   operand/result width in bits; N % STAGES == 0
//  STAGES  2   pipeline depth = number of carry chunks, 1..N; chunk width W = N/STAGES
// PORTS
//  clk        in   1  single clock, rising edge
//  rst        in   1  synchronous reset, active-high
//  in_valid   in   1  operand beat valid
//  in_ready   out  1  block accepts a beat this cycle
//  a          in   N  operand A
//  b          in   N  operand B
//  cin        in   1  carry in (for SUB: 1 = no borrow)
//  sub        in   1  0: a+b+cin; 1: a+~b+cin
//  out_valid  out  1  result beat valid
//  out_ready  in   1  downstream accepts result
//  s          out  N  result
//  cout       out  1  carry out of bit N-1
//  ovf        out  1  signed overflow: sign(a)==sign(b') and sign(raw sum)!=sign(a), b' = sub ? ~b : b
//  zero       out  1  s == 0 (evaluated on the output value s)
// BEHAVIOUR
//  - Reset: out_valid=0, s=0, cout=0, ovf=0, zero=0; all stage valid bits 0; in_ready=1 the cycle after.
//  - Beat accepted when in_valid && in_ready. Latency exactly STAGES cycles to out_valid at zero backpressure.
//  - Stage k (0..STAGES-1) adds chunk [k*W +: W] using the carry registered by stage k-1 (stage 0 uses cin).
//  - Operand chunks above k are skewed (delayed) with the beat; result chunks below k are carried along.
//  - Throughput: one beat per cycle; up to STAGES beats in flight.
//  - Stall: advance = !out_valid || out_ready; every stage register and in_ready follow advance
//    (in_ready = advance). No bubble collapsing; flow is a single global enable.
//  - out_valid && !out_ready: s/cout/ovf/zero held stable until the handshake completes.
//  - Simultaneous output pop and input push in the same cycle: both occur; no beat is lost.
//  - Empty stages carry valid=0 and do not raise out_valid; data registers may hold stale values.
//  - Wrap-around: result is modulo 2^N; cout reports the carry, no other effect.
//  - rst asserted mid-operation: all in-flight beats discarded, outputs return to reset values next edge.
//  - STAGES=1: one registered ripple adder; latency 1.
// CONFIGURATION
//  - Macro PIPE_ADDSUB_SAT_EN.
//  - Defined: when ovf=1, s saturates to 0x7F..F if sign(a)=0, else 0x80..0; cout unchanged;
//    zero evaluated after saturation.
//  - Undefined: s is the raw wrapped sum; no saturation logic is generated.
//  - ovf is reported identically in both builds.
// STRUCTURE
//  - Shared package: stage-record typedef (valid, result chunks, skewed operands, carry, sub);
//    localparam W; flag-bit index constants.
//  - Sub-module addsub_chunk #(W): combinational W-bit ripple slice, in a, b, cin, sub; out s, cout,
//    msb carry-in (for ovf). Built from existing full_adder cells; one instance per stage.
//  - Top: generate loop of STAGES register banks plus a final flag/saturation stage folded into the last bank.
// TESTING
//  - N=8,STAGES=2: a=0x12,b=0x34,cin=0,sub=0 -> after 2 cycles s=0x46,cout=0,ovf=0,zero=0.
//  - sub=1,cin=1,a=0x05,b=0x05 -> s=0x00,cout=1,zero=1,ovf=0; a=0x00,b=0x01 -> s=0xFF,cout=0.
//  - a=0x7F,b=0x01,sub=0 -> ovf=1; s=0x80 without macro, s=0x7F with PIPE_ADDSUB_SAT_EN.
//  - Stream 4 beats back-to-back, hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 while
//    stalled, s held stable, all 4 results emerge in order, none dropped or duplicated.
//  - Pulse rst with 2 beats in flight -> out_valid=0 and s=0 next cycle; no stale beat ever appears.
//  - Randomised sweep N=16, STAGES in {1,4,16} against behavioural model a +/- b: 10k beats, no mismatch.

Source files
------------

// File: rtl/pipe_addsub_pkg.sv
// Shared constants for the pipelined adder/subtractor: default geometry and
// the bit positions of the status flags carried in the final register bank.
package pipe_addsub_pkg;

  localparam int DEF_N      = 8;
  localparam int DEF_STAGES = 2;
  localparam int DEF_W      = DEF_N / DEF_STAGES;

  localparam int FLAG_COUT = 0;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_ZERO = 2;
  localparam int NFLAGS    = 3;

  typedef logic [NFLAGS-1:0] flags_t;

  // Low bit of carry chunk k for chunk width w.
  function automatic int chunk_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational W-bit ripple add/subtract slice; also exposes the carry into
// its top bit so the last slice can derive signed overflow.
module addsub_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         msb_cin
);

  logic [W:0]   c;
  logic [W-1:0] bx;

  assign c[0] = cin;
  assign bx   = b ^ {W{sub}};

  for (genvar i = 0; i < W; i++) begin : g_bit
    full_adder u_fa (
      .a  (a[i]),
      .b  (bx[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  assign cout    = c[W];
  assign msb_cin = c[W-1];

endmodule

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of every ripple slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined N-bit adder/subtractor, STAGES carry chunks, valid/ready flow
// under one global enable. Define PIPE_ADDSUB_SAT_EN for saturating results.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int STAGES = DEF_STAGES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int W = N / STAGES;
  localparam logic [N-1:0] SAT_MIN = N'(1) << (N - 1);
  localparam logic [N-1:0] SAT_MAX = ~SAT_MIN;

  // One register bank per stage: operands travel whole (upper chunks still
  // pending), results accumulate chunk by chunk, flags only matter at the end.
  typedef struct packed {
    logic         valid;
    logic         sub;
    logic         carry;
    logic         msb_cin;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] res;
    flags_t       flags;
  } stage_t;

  logic   advance;
  stage_t in_rec;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    in_rec       = '0;
    in_rec.valid = in_valid;
    in_rec.sub   = sub;
    in_rec.carry = cin;
    in_rec.a     = a;
    in_rec.b     = b;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_t       src;
    stage_t       d;
    stage_t       q;
    logic [W-1:0] cs;
    logic         cc;
    logic         cm;
    logic         ovf_raw;

    if (k == 0) begin : g_src_in
      assign src = in_rec;
    end else begin : g_src_prev
      assign src = g_stage[k-1].q;
    end

    addsub_chunk #(.W(W)) u_chunk (
      .a       (src.a[chunk_lo(k, W) +: W]),
      .b       (src.b[chunk_lo(k, W) +: W]),
      .cin     (src.carry),
      .sub     (src.sub),
      .s       (cs),
      .cout    (cc),
      .msb_cin (cm)
    );

    // Carry into the sign bit differing from carry out is exactly the
    // "same operand signs, different result sign" overflow condition.
    assign ovf_raw = cc ^ cm;

    // NOTE: d starts as a full copy of src so every field is assigned on
    // every path; a missing default here would infer a latch.
    always_comb begin
      d                            = src;
      d.res[chunk_lo(k, W) +: W]   = cs;
      d.carry                      = cc;
      d.msb_cin                    = cm;
      if (k == STAGES - 1) begin
`ifdef PIPE_ADDSUB_SAT_EN
        if (ovf_raw) begin
          d.res = src.a[N-1] ? SAT_MIN : SAT_MAX;
        end
`endif
        d.flags[FLAG_COUT] = cc;
        d.flags[FLAG_OVF]  = ovf_raw;
        d.flags[FLAG_ZERO] = (d.res == '0);
      end
    end

    // NOTE: data fields are reset along with valid because the last bank
    // drives s/cout/ovf/zero directly and those must read zero after reset.
    // NOTE: sequential state uses non-blocking assignment so every bank
    // samples its predecessor's pre-edge value.
    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else if (advance) begin
        q <= d;
      end
    end
  end

  stage_t last;
  assign last = g_stage[STAGES-1].q;

  assign out_valid = last.valid;
  assign s         = last.res;
  assign cout      = last.flags[FLAG_COUT];
  assign ovf       = last.flags[FLAG_OVF];
  assign zero      = last.flags[FLAG_ZERO];

endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub: driver pushes model results, a monitor
// pops them on each output handshake; randomized beats and backpressure.
module tb_pipe_addsub;

  localparam int N      = 8;
  localparam int STAGES = 2;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         cout;
  logic         ovf;
  logic         zero;

  pipe_addsub #(.N(N), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   bp_mode = 0;  // 0: always ready, 1: random, 2: stalled

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input int unsigned ta, input int unsigned tb_,
                                 input int unsigned tc, input int unsigned ts);
    exp_t        e;
    int unsigned mask  = (1 << N) - 1;
    int unsigned bb    = ts != 0 ? (~tb_ & mask) : tb_;
    int unsigned total = ta + bb + tc;
    int unsigned res   = total & mask;
    int unsigned sa    = (ta >> (N - 1)) & 1;
    int unsigned sbb   = (bb >> (N - 1)) & 1;
    int unsigned sr    = (res >> (N - 1)) & 1;
    e.cout = ((total >> N) & 1) != 0;
    e.ovf  = (sa == sbb) && (sr != sa);
`ifdef PIPE_ADDSUB_SAT_EN
    if (e.ovf) res = (sa != 0) ? (1 << (N - 1)) : ((1 << (N - 1)) - 1);
`endif
    e.s    = res[N-1:0];
    e.zero = (res == 0);
    return e;
  endfunction

  // Backpressure changes just after the rising edge, so it is stable at negedge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops on handshake, checks hold-stability and in_ready while stalled.
  initial begin
    logic         held_valid;
    logic [N-1:0] held_s;
    logic [2:0]   held_f;
    exp_t         e;
    held_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_valid = 1'b0;
      end else begin
        if (held_valid) begin
          check("hold_valid", out_valid, 1);
          check("hold_s", s, held_s);
          check("hold_flags", {cout, ovf, zero}, held_f);
        end
        held_valid = 1'b0;
        if (out_valid && !out_ready) begin
          check("stall_in_ready", in_ready, 0);
          held_valid = 1'b1;
          held_s     = s;
          held_f     = {cout, ovf, zero};
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_beat: got s=0x%0h, expected no beat", s);
          end else begin
            e = sb.pop_front();
            check("s", s, e.s);
            check("cout", cout, e.cout);
            check("ovf", ovf, e.ovf);
            check("zero", zero, e.zero);
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send(input logic [N-1:0] ta, input logic [N-1:0] tb_,
                      input logic tc, input logic ts);
    int guard = 0;
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck at 0, expected 1 within 200 cycles");
    end else begin
      sb.push_back(model(ta, tb_, tc, ts));
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int lat;
    int guard;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_s", s, 0);
    check("rst_flags", {cout, ovf, zero}, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Latency on an idle pipe: 0x12 + 0x34.
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    sb.push_back(model(32'h12, 32'h34, 0, 0));
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, STAGES);
    idle(4);

    // Boundary vectors: equal subtract, borrow, +/- overflow, wrap to zero.
    send(8'h05, 8'h05, 1'b1, 1'b1);
    send(8'h00, 8'h01, 1'b1, 1'b1);
    send(8'h7F, 8'h01, 1'b0, 1'b0);
    send(8'h80, 8'h80, 1'b0, 1'b0);
    send(8'hFF, 8'h01, 1'b0, 1'b0);
    send(8'h80, 8'h01, 1'b1, 1'b1);
    idle(6);

    // Four back-to-back beats with a 3-cycle output stall in the middle.
    fork
      begin
        repeat (2) @(posedge clk);
        bp_mode = 2;
        repeat (3) @(posedge clk);
        bp_mode = 0;
      end
    join_none
    for (int i = 0; i < 4; i++) send(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
    idle(10);

    // Reset with two beats in flight and the output stalled.
    bp_mode = 2;
    @(posedge clk);
    @(negedge clk);
    send(8'h11, 8'h22, 1'b0, 1'b0);
    send(8'h33, 8'h44, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_s", s, 0);
    check("midrst_in_ready", in_ready, 1);
    rst = 1'b0;
    bp_mode = 0;
    idle(8);

    // Randomized sweep with random gaps and random backpressure.
    bp_mode = 1;
    for (int i = 0; i < 400; i++) begin
      send(N'($urandom), N'($urandom), 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    in_valid = 1'b0;
    bp_mode = 0;
    guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_empty", sb.size(), 0);
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
